// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register indices, bit positions and bus polarity shared by the timer files.
// Latency: n/a (constants, types and a read-back helper only).
// Backpressure: n/a.
package bus_timer_pkg;

  typedef logic [1:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // Register indices on the word-addressed bus
  localparam reg_addr_t TIMER_ADDR_CTRL  = 2'd0;
  localparam reg_addr_t TIMER_ADDR_INTR  = 2'd1;
  localparam reg_addr_t TIMER_ADDR_EXPR  = 2'd2;
  localparam reg_addr_t TIMER_ADDR_COUNT = 2'd3;

  // Bit positions inside CTRL and INTR
  localparam int TIMER_START_BIT    = 0;
  localparam int TIMER_PERIODIC_BIT = 1;
  localparam int TIMER_IRQ_BIT      = 0;

  // Active-low strobes: ENABLE is the asserted level
  localparam logic BUS_ENABLE  = 1'b0;
  localparam logic BUS_DISABLE = 1'b1;
  localparam logic BUS_READ    = 1'b1;
  localparam logic BUS_WRITE   = 1'b0;

  // CTRL read-back word; undefined bits read as zero
  function automatic word_t ctrl_word(input logic start, input logic periodic);
    word_t w;
    w = '0;
    w[TIMER_START_BIT]    = start;
    w[TIMER_PERIODIC_BIT] = periodic;
    return w;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// bus_timer_if: address-strobe / ready system bus plus the timer interrupt line.
// Latency: n/a (wires only).
// Backpressure: slave answers every request after one cycle; no wait states.
interface bus_timer_if;
  import bus_timer_pkg::*;

  logic      CS_;
  logic      As_;
  logic      RW;
  reg_addr_t Addr;
  word_t     WrData;
  word_t     RdData;
  logic      Rdy_;
  logic      Irq;

  modport master (
    output CS_, As_, RW, Addr, WrData,
    input  RdData, Rdy_, Irq
  );

  modport slave (
    input  CS_, As_, RW, Addr, WrData,
    output RdData, Rdy_, Irq
  );

endinterface

// File: rtl/bus_timer_prescaler.sv
// bus_timer_prescaler: divides the running timer down to one tick every PRESCALE cycles.
// Latency: first tick PRESCALE cycles after start rises or a clear.
// Backpressure: none; tick is a single-cycle combinational pulse.
module bus_timer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase;

  // Gate on start so a stale phase can never produce a tick while stopped
  assign tick = start && (phase == LAST);

  // Phase counter: held at zero while stopped or on a clear, wraps after LAST
  always_ff @(posedge clk) begin
    if (reset || clear || !start) begin
      phase <= '0;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + CW'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped interval timer (CTRL/INTR/EXPR/COUNT), one-shot or periodic, level irq.
// Latency: Rdy_/RdData one cycle after the request edge; Irq one cycle after the expiring tick edge.
// Backpressure: none; every request is acknowledged the next cycle. Prescaler: BUS_TIMER_PRESCALER_EN.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  bus_timer_if.slave  bus
);

  logic  req;
  logic  rd_req;
  logic  wr_req;
  logic  wr_ctrl;
  logic  wr_intr;
  logic  wr_expr;
  logic  wr_count;

  logic  start;
  logic  periodic;
  logic  irq;
  word_t expr;
  word_t count;

  logic  tick;
  logic  expire;

  word_t rd_mux;
  word_t rd_data;
  logic  ack;
  logic  irq_pin;

  assign req      = (bus.CS_ == BUS_ENABLE) && (bus.As_ == BUS_ENABLE);
  assign rd_req   = req && (bus.RW == BUS_READ);
  assign wr_req   = req && (bus.RW == BUS_WRITE);
  assign wr_ctrl  = wr_req && (bus.Addr == TIMER_ADDR_CTRL);
  assign wr_intr  = wr_req && (bus.Addr == TIMER_ADDR_INTR);
  assign wr_expr  = wr_req && (bus.Addr == TIMER_ADDR_EXPR);
  assign wr_count = wr_req && (bus.Addr == TIMER_ADDR_COUNT);

`ifdef BUS_TIMER_PRESCALER_EN
  // Restart the prescale phase whenever software touches COUNT or CTRL
  bus_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .clear (wr_ctrl || wr_count),
    .tick  (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign tick = start;
`endif

  // Compare uses the pre-edge EXPR, so an EXPR write on a tick edge affects the next tick only
  assign expire = tick && (count == expr);

  // CTRL: a bus write overrides the one-shot auto-clear on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      start    <= 1'b0;
      periodic <= 1'b0;
    end else if (wr_ctrl) begin
      start    <= bus.WrData[TIMER_START_BIT];
      periodic <= bus.WrData[TIMER_PERIODIC_BIT];
    end else if (expire && !periodic) begin
      start    <= 1'b0;
    end
  end

  // INTR: expiry takes priority so a clear racing an expiry never loses the interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (expire) begin
      irq <= 1'b1;
    end else if (wr_intr) begin
      irq <= bus.WrData[TIMER_IRQ_BIT];
    end
  end

  // EXPR: plain software register
  always_ff @(posedge clk) begin
    if (reset) begin
      expr <= '0;
    end else if (wr_expr) begin
      expr <= bus.WrData;
    end
  end

  // COUNT: a bus write beats a tick; otherwise reload on expiry or increment modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.WrData;
    end else if (tick) begin
      count <= expire ? '0 : count + 32'd1;
    end
  end

  // Read mux over the pre-edge register values
  always_comb begin
    rd_mux = '0;
    case (bus.Addr)
      TIMER_ADDR_CTRL:  rd_mux = ctrl_word(start, periodic);
      TIMER_ADDR_INTR:  rd_mux[TIMER_IRQ_BIT] = irq;
      TIMER_ADDR_EXPR:  rd_mux = expr;
      TIMER_ADDR_COUNT: rd_mux = count;
      default:          rd_mux = '0;
    endcase
  end

  // Bus response and irq pin: registered, one-cycle ack, data zero outside the ack cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ack     <= 1'b0;
      rd_data <= '0;
      irq_pin <= 1'b0;
    end else begin
      ack     <= req;
      rd_data <= rd_req ? rd_mux : '0;
      irq_pin <= irq;
    end
  end

  assign bus.Rdy_   = ack ? BUS_ENABLE : BUS_DISABLE;
  assign bus.RdData = rd_data;
  assign bus.Irq    = irq_pin;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed scenarios plus randomized bus traffic checked against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_timer;
  import bus_timer_pkg::*;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_timer_if bus();

  bus_timer #(.PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic        m_start, m_periodic, m_irq, m_irq_pin, m_ack;
  logic [31:0] m_expr, m_count, m_rd;
  int          m_pre;

  always @(posedge clk) begin
    logic req, wr, tick, hit, clr_pre, old_start;
    logic [31:0] regval;
    if (reset) begin
      m_start = 0; m_periodic = 0; m_irq = 0; m_irq_pin = 0; m_ack = 0;
      m_expr = 0; m_count = 0; m_rd = 0; m_pre = 0;
    end else begin
      req = (bus.CS_ === 1'b0) && (bus.As_ === 1'b0);
      wr  = req && (bus.RW === 1'b0);
      case (bus.Addr)
        2'd0: regval = {30'd0, m_periodic, m_start};
        2'd1: regval = {31'd0, m_irq};
        2'd2: regval = m_expr;
        default: regval = m_count;
      endcase
      m_ack = req;
      m_rd = (req && bus.RW === 1'b1) ? regval : 32'd0;
      m_irq_pin = m_irq;
`ifdef BUS_TIMER_PRESCALER_EN
      tick = m_start && (m_pre == P - 1);
`else
      tick = m_start;
`endif
      hit = tick && (m_count == m_expr);
      old_start = m_start;
      clr_pre = 0;
      if (tick) m_count = hit ? 32'd0 : m_count + 32'd1;
      if (hit) begin
        if (!m_periodic) m_start = 0;
      end
      if (wr && bus.Addr == 2'd1) m_irq = bus.WrData[0];
      if (hit) m_irq = 1;
      if (wr && bus.Addr == 2'd0) begin
        m_start = bus.WrData[0]; m_periodic = bus.WrData[1]; clr_pre = 1;
      end
      if (wr && bus.Addr == 2'd2) m_expr = bus.WrData;
      if (wr && bus.Addr == 2'd3) begin m_count = bus.WrData; clr_pre = 1; end
      if (!old_start || clr_pre || tick) m_pre = 0;
      else m_pre = m_pre + 1;
    end
  end

  // ---------------- bus helpers (start and end at a falling edge) ----------------
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic do_req(input logic rw, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic rdy);
    bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = rw; bus.Addr = a; bus.WrData = d;
    @(negedge clk);
    bus.CS_ = 1'b1; bus.As_ = 1'b1;
    rd = bus.RdData; rdy = bus.Rdy_;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.CS_ = 1'b1; bus.As_ = 1'b1; bus.RW = 1'b1; bus.Addr = 2'd0; bus.WrData = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd; logic rdy;
    apply_reset();
    n_checks++; if (bus.Rdy_ !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", bus.Rdy_); end
    n_checks++; if (bus.RdData !== 32'd0) begin n_fail++; $display("FAIL reset_rddata got %h want 0", bus.RdData); end
    n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.Irq); end
    for (int a = 0; a < 4; a++) begin
      do_req(BUS_READ, 2'(a), 32'hFFFF_FFFF, rd, rdy);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_read_rdy reg=%0d got %b want 0", a, rdy); end
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_read_val reg=%0d got %h want 0", a, rd); end
      idle();
      n_checks++; if (bus.Rdy_ !== 1'b1) begin n_fail++; $display("FAIL reset_read_rdy_drop reg=%0d got %b want 1", a, bus.Rdy_); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd, exp_cnt; logic rdy;
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd5, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h1, rd, rdy);
    // read at edge N+k returns the count after edge N+k-1
    for (int k = 1; k <= 10; k++) begin
      do_req(BUS_READ, TIMER_ADDR_COUNT, 32'd0, rd, rdy);
      exp_cnt = (k - 1 <= 5) ? 32'(k - 1) : 32'd0;
      n_checks++; if (rd !== exp_cnt) begin n_fail++; $display("FAIL oneshot_count k=%0d got %h want %h", k, rd, exp_cnt); end
      n_checks++; if (bus.Irq !== (k >= 7)) begin n_fail++; $display("FAIL oneshot_irq k=%0d got %b want %b", k, bus.Irq, (k >= 7)); end
    end
    do_req(BUS_READ, TIMER_ADDR_CTRL, 32'd0, rd, rdy);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oneshot_ctrl_cleared got %h want 0", rd); end
  endtask

  task automatic test_periodic();
    logic [31:0] rd; logic rdy;
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd3, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h3, rd, rdy);           // edge N
    for (int k = 1; k <= 5; k++) begin
      idle();
      n_checks++; if (bus.Irq !== (k >= 5)) begin n_fail++; $display("FAIL periodic_first_irq k=%0d got %b want %b", k, bus.Irq, (k >= 5)); end
    end
    do_req(BUS_WRITE, TIMER_ADDR_INTR, 32'd0, rd, rdy);           // N+6
    idle();                                                        // N+7
    n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL periodic_clear got %b want 0", bus.Irq); end
    idle();                                                        // N+8 (expiry)
    n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL periodic_pre_rearm got %b want 0", bus.Irq); end
    idle();                                                        // N+9
    n_checks++; if (bus.Irq !== 1'b1) begin n_fail++; $display("FAIL periodic_rearm got %b want 1", bus.Irq); end
    idle(); idle();                                                // N+10, N+11
    do_req(BUS_WRITE, TIMER_ADDR_INTR, 32'd0, rd, rdy);           // N+12 (expiry)
    do_req(BUS_READ, TIMER_ADDR_INTR, 32'd0, rd, rdy);            // N+13
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL periodic_clear_vs_expiry_reg got %h want 1", rd); end
    n_checks++; if (bus.Irq !== 1'b1) begin n_fail++; $display("FAIL periodic_clear_vs_expiry_pin got %b want 1", bus.Irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rdy;
    bus.CS_ = 1'b0; bus.As_ = 1'b0; bus.RW = BUS_READ; bus.Addr = TIMER_ADDR_EXPR;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.CS_ = 1'b1; bus.As_ = 1'b1;
    n_checks++; if (bus.Rdy_ !== 1'b1) begin n_fail++; $display("FAIL reset_mid_rdy got %b want 1", bus.Rdy_); end
    n_checks++; if (bus.Irq !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq got %b want 0", bus.Irq); end
    do_req(BUS_READ, TIMER_ADDR_EXPR, 32'd0, rd, rdy);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_mid_expr got %h want 0", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic rdy;
    logic [31:0] exp_seq [5];
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'd0;
    exp_seq[3] = 32'd1;         exp_seq[4] = 32'd0;
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_COUNT, 32'hFFFF_FFFE, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd1, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h1, rd, rdy);
    for (int k = 1; k <= 5; k++) begin
      do_req(BUS_READ, TIMER_ADDR_COUNT, 32'd0, rd, rdy);
      n_checks++; if (rd !== exp_seq[k-1]) begin n_fail++; $display("FAIL wrap_count k=%0d got %h want %h", k, rd, exp_seq[k-1]); end
      n_checks++; if (bus.Irq !== (k >= 5)) begin n_fail++; $display("FAIL wrap_irq k=%0d got %b want %b", k, bus.Irq, (k >= 5)); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd; logic rdy;
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd2, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h3, rd, rdy);           // N
    idle(); idle();
    do_req(BUS_WRITE, TIMER_ADDR_COUNT, 32'h100, rd, rdy);        // N+3 expiry
    do_req(BUS_READ, TIMER_ADDR_COUNT, 32'd0, rd, rdy);
    n_checks++; if (rd !== 32'h100) begin n_fail++; $display("FAIL collide_count got %h want 100", rd); end
    do_req(BUS_READ, TIMER_ADDR_INTR, 32'd0, rd, rdy);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL collide_irq got %h want 1", rd); end
    // CTRL write racing the one-shot auto-clear
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd2, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h1, rd, rdy);           // N
    idle(); idle();
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h1, rd, rdy);           // N+3 expiry
    do_req(BUS_READ, TIMER_ADDR_CTRL, 32'd0, rd, rdy);
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL collide_ctrl got %h want 1", rd); end
    // deselected request
    bus.CS_ = 1'b1; bus.As_ = 1'b0; bus.RW = BUS_READ; bus.Addr = TIMER_ADDR_EXPR;
    @(negedge clk);
    bus.As_ = 1'b1;
    n_checks++; if (bus.Rdy_ !== 1'b1) begin n_fail++; $display("FAIL deselect_rdy got %b want 1", bus.Rdy_); end
    n_checks++; if (bus.RdData !== 32'd0) begin n_fail++; $display("FAIL deselect_data got %h want 0", bus.RdData); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, va, vb; logic rdy;
    va = $urandom; vb = $urandom;
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, va, rd, rdy);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_wr1_rdy got %b want 0", rdy); end
    do_req(BUS_READ, TIMER_ADDR_EXPR, 32'd0, rd, rdy);
    n_checks++; if (rdy !== 1'b0 || rd !== va) begin n_fail++; $display("FAIL b2b_rd1 got rdy=%b %h want rdy=0 %h", rdy, rd, va); end
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, vb, rd, rdy);
    n_checks++; if (rdy !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL b2b_wr2 got rdy=%b %h want rdy=0 0", rdy, rd); end
    do_req(BUS_READ, TIMER_ADDR_EXPR, 32'd0, rd, rdy);
    n_checks++; if (rdy !== 1'b0 || rd !== vb) begin n_fail++; $display("FAIL b2b_rd2 got rdy=%b %h want rdy=0 %h", rdy, rd, vb); end
  endtask

`ifdef BUS_TIMER_PRESCALER_EN
  task automatic test_prescale();
    logic [31:0] rd; logic rdy;
    apply_reset();
    do_req(BUS_WRITE, TIMER_ADDR_EXPR, 32'd2, rd, rdy);
    do_req(BUS_WRITE, TIMER_ADDR_CTRL, 32'h1, rd, rdy);
    // ticks every P edges; third tick expires, pin follows one edge later
    for (int k = 1; k <= 3 * P + 3; k++) begin
      idle();
      n_checks++; if (bus.Irq !== (k >= 3 * P + 1)) begin n_fail++; $display("FAIL prescale_irq k=%0d got %b want %b", k, bus.Irq, (k >= 3 * P + 1)); end
    end
  endtask
`endif

  task automatic test_random();
    int r;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      bus.RW = 1'($urandom_range(0, 1));
      bus.Addr = 2'($urandom_range(0, 3));
      case (bus.Addr)
        2'd0: bus.WrData = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        2'd1: bus.WrData = 32'($urandom_range(0, 1));
        2'd2: bus.WrData = 32'($urandom_range(0, 6));
        default: bus.WrData = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                           : 32'($urandom_range(0, 8));
      endcase
      if (r < 40)      begin bus.CS_ = 1'b1; bus.As_ = 1'b1; end
      else if (r < 48) begin bus.CS_ = 1'b1; bus.As_ = 1'b0; end
      else if (r < 53) begin bus.CS_ = 1'b0; bus.As_ = 1'b1; end
      else             begin bus.CS_ = 1'b0; bus.As_ = 1'b0; end
      @(negedge clk);
      n_checks++; if (bus.Rdy_ !== !m_ack) begin n_fail++; $display("FAIL rand_rdy i=%0d got %b want %b", i, bus.Rdy_, !m_ack); end
      n_checks++; if (bus.RdData !== m_rd) begin n_fail++; $display("FAIL rand_rddata i=%0d got %h want %h", i, bus.RdData, m_rd); end
      n_checks++; if (bus.Irq !== m_irq_pin) begin n_fail++; $display("FAIL rand_irq i=%0d got %b want %b", i, bus.Irq, m_irq_pin); end
    end
    bus.CS_ = 1'b1; bus.As_ = 1'b1;
  endtask

  initial begin
    bus.CS_ = 1'b1; bus.As_ = 1'b1; bus.RW = 1'b1; bus.Addr = 2'd0; bus.WrData = '0;
    @(negedge clk);
    test_reset();
`ifdef BUS_TIMER_PRESCALER_EN
    test_prescale();
`else
    test_oneshot();
    test_periodic();
    test_reset_mid();
    test_wrap();
    test_collision();
`endif
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
